// File: rtl/snn_config_loader_if.sv
// Byte-serial configuration handshake: a frame-open pulse plus a valid/ready data byte.
interface snn_config_loader_if;
    logic       cfg_start;
    logic [7:0] cfg_data;
    logic       cfg_valid;
    logic       cfg_ready;

    modport master (output cfg_start, cfg_data, cfg_valid, input cfg_ready);
    modport slave  (input cfg_start, cfg_data, cfg_valid, output cfg_ready);
endinterface

// File: rtl/snn_config_loader.sv
// Loads a checksummed byte frame into a shadow image and commits it atomically to the
// active network parameters; gates the network enable until a valid image is live.
module snn_config_loader #(
    parameter int WEIGHT_BITS = 288,
    parameter int DELAY_BITS  = 576,
    parameter int PARAM_W     = 6
) (
    input  logic                   clk,
    input  logic                   reset_n,
    snn_config_loader_if.slave     cfg,
    input  logic                   enable_in,
    output logic                   net_enable,
    output logic [WEIGHT_BITS-1:0] weights,
    output logic [DELAY_BITS-1:0]  delays,
    output logic [PARAM_W-1:0]     threshold,
    output logic [PARAM_W-1:0]     decay,
    output logic [PARAM_W-1:0]     refractory_period,
    output logic                   cfg_done,
    output logic                   cfg_error,
    output logic                   config_valid
);
    localparam int STREAM_BITS   = WEIGHT_BITS + DELAY_BITS + 3 * PARAM_W;
    localparam int PAYLOAD_BYTES = (STREAM_BITS + 7) / 8;
    localparam int IMG_BITS      = PAYLOAD_BYTES * 8;
    localparam int PTR_W         = $clog2(PAYLOAD_BYTES + 1);
    localparam int THR_LSB       = WEIGHT_BITS + DELAY_BITS;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(PAYLOAD_BYTES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

    state_t               state, state_n;
    logic [PTR_W-1:0]     ptr;
    logic [7:0]           acc;
    logic [IMG_BITS-1:0]  shadow;
    logic                 ready, accept, clr_frame, take, set_err;

    assign ready         = (state == LOAD) || (state == CHECK);
    assign cfg.cfg_ready = ready;
    assign cfg_done      = (state == COMMIT);
    // A start pulse always wins over a byte offered in the same cycle.
    assign accept        = cfg.cfg_valid & ready & ~cfg.cfg_start;

    always_comb begin
        state_n   = state;
        clr_frame = 1'b0;
        take      = 1'b0;
        set_err   = 1'b0;
        if (cfg.cfg_start) begin
            // In COMMIT the active copy still updates this cycle; the new frame follows.
            state_n   = LOAD;
            clr_frame = 1'b1;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    take = 1'b1;
                    if (ptr == LAST) state_n = CHECK;
                end
                CHECK: if (accept) begin
                    if (cfg.cfg_data == acc) begin
                        state_n = COMMIT;
                    end else begin
                        set_err = 1'b1;
                        state_n = IDLE;
                    end
                end
                COMMIT:  state_n = IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state             <= IDLE;
            ptr               <= '0;
            acc               <= '0;
            shadow            <= '0;
            weights           <= '0;
            delays            <= '0;
            threshold         <= '0;
            decay             <= '0;
            refractory_period <= '0;
            cfg_error         <= 1'b0;
            config_valid      <= 1'b0;
            net_enable        <= 1'b0;
        end else begin
            state <= state_n;
            if (clr_frame) begin
                ptr <= '0;
                acc <= '0;
            end else if (take) begin
                shadow[{ptr, 3'b000} +: 8] <= cfg.cfg_data;
                acc                        <= acc ^ cfg.cfg_data;
                ptr                        <= ptr + 1'b1;
            end
            if (clr_frame)    cfg_error <= 1'b0;
            else if (set_err) cfg_error <= 1'b1;
            if (state == COMMIT) begin
                weights           <= shadow[WEIGHT_BITS-1:0];
                delays            <= shadow[WEIGHT_BITS +: DELAY_BITS];
                threshold         <= shadow[THR_LSB +: PARAM_W];
                decay             <= shadow[THR_LSB + PARAM_W +: PARAM_W];
                refractory_period <= shadow[THR_LSB + 2*PARAM_W +: PARAM_W];
                config_valid      <= 1'b1;
            end
            net_enable <= enable_in & config_valid & (state == IDLE);
        end
    end
endmodule
